// File: rtl/pulse_period_meter.sv
// Measures clk cycles between rising edges of pulse and hands each result out over valid/ack.
// Define PPM_MINMAX_EN to add min/max period tracking with clr_minmax.
module pulse_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  input  logic             enable,
  input  logic             ack,
`ifdef PPM_MINMAX_EN
  input  logic             clr_minmax,
  output logic [WIDTH-1:0] min_period,
  output logic [WIDTH-1:0] max_period,
`endif
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             overflow,
  output logic             missed
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state, state_next;
  logic             pulse_d;
  logic             pulse_edge;
  logic [WIDTH-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] period_next;
  logic             valid_next, overflow_next, missed_next;
  logic             sample_take, sample_drop;

  assign pulse_edge = pulse & ~pulse_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pulse_d  <= 1'b0;
      cnt      <= '0;
      period   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      missed   <= 1'b0;
    end else begin
      state    <= state_next;
      pulse_d  <= pulse;
      cnt      <= cnt_next;
      period   <= period_next;
      valid    <= valid_next;
      overflow <= overflow_next;
      missed   <= missed_next;
    end
  end

  // A sample is taken whenever the previous result is gone or being acked this cycle.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    period_next   = period;
    valid_next    = valid;
    overflow_next = overflow;
    missed_next   = missed;
    sample_take   = 1'b0;
    sample_drop   = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (pulse_edge && enable) begin
          state_next = MEASURE;
          cnt_next   = CNT_ONE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (pulse_edge) begin
          cnt_next = CNT_ONE;
          if (!valid || ack) sample_take = 1'b1;
          else               sample_drop = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (sample_take) begin
      period_next   = cnt;
      valid_next    = 1'b1;
      overflow_next = (cnt == CNT_MAX);
      missed_next   = 1'b0;
    end else if (sample_drop) begin
      missed_next = 1'b1;
    end else if (valid && ack) begin
      valid_next    = 1'b0;
      overflow_next = 1'b0;
      missed_next   = 1'b0;
    end
  end

`ifdef PPM_MINMAX_EN
  // A clear coinciding with an accepted sample seeds both extremes with that sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_period <= CNT_MAX;
      max_period <= '0;
    end else if (sample_take) begin
      if (clr_minmax) begin
        min_period <= cnt;
        max_period <= cnt;
      end else begin
        if (cnt < min_period) min_period <= cnt;
        if (cnt > max_period) max_period <= cnt;
      end
    end else if (clr_minmax) begin
      min_period <= CNT_MAX;
      max_period <= '0;
    end
  end
`endif

endmodule
